// File: rtl/pwm_deadtime.sv
// Complementary half-bridge gate driver: turns a single-ended PWM into out_hi/out_lo
// with a programmable dead time, swallowing and counting pulses shorter than it.
module pwm_deadtime #(
    parameter int DT_W  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_in,
    input  logic [DT_W-1:0]  dead_time,
    input  logic             clr_cnt,
    output logic             out_hi,
    output logic             out_lo,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] drop_cnt
);

    // One-hot so the gate outputs come straight off a single flop each.
    typedef enum logic [4:0] {
        S_OFF      = 5'b00001,
        S_LO_ON    = 5'b00010,
        S_DT_TO_HI = 5'b00100,
        S_HI_ON    = 5'b01000,
        S_DT_TO_LO = 5'b10000
    } state_t;

    localparam int LO_BIT = 1;
    localparam int HI_BIT = 3;

    state_t           state_q, state_d;
    logic             pwm_q, pwm_d;
    logic [DT_W-1:0]  dt_cnt_q, dt_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [DT_W-1:0]  d_eff;
    logic             drop;

    always_comb begin
        pwm_d    = pwm_in;
        d_eff    = (dead_time == '0) ? DT_W'(1) : dead_time;
        state_d  = state_q;
        dt_cnt_d = '0;
        drop     = 1'b0;
        if (!en) begin
            state_d = S_OFF;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (pwm_q) begin
                        state_d  = S_DT_TO_HI;
                        dt_cnt_d = d_eff;
                    end else begin
                        state_d = S_LO_ON;
                    end
                end
                S_LO_ON: begin
                    if (pwm_q) begin
                        state_d  = S_DT_TO_HI;
                        dt_cnt_d = d_eff;
                    end
                end
                S_DT_TO_HI: begin
                    if (!pwm_q) begin
                        state_d = S_LO_ON;
                        drop    = 1'b1;
                    end else if (dt_cnt_q == DT_W'(1)) begin
                        state_d = S_HI_ON;
                    end else begin
                        dt_cnt_d = dt_cnt_q - DT_W'(1);
                    end
                end
                S_HI_ON: begin
                    if (!pwm_q) begin
                        state_d  = S_DT_TO_LO;
                        dt_cnt_d = d_eff;
                    end
                end
                S_DT_TO_LO: begin
                    if (pwm_q) begin
                        state_d = S_HI_ON;
                        drop    = 1'b1;
                    end else if (dt_cnt_q == DT_W'(1)) begin
                        state_d = S_LO_ON;
                    end else begin
                        dt_cnt_d = dt_cnt_q - DT_W'(1);
                    end
                end
                default: state_d = S_OFF;
            endcase
        end

        // Clear beats a simultaneous increment; the count sticks at all-ones.
        drop_cnt_d = drop_cnt_q;
        if (clr_cnt) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_OFF;
            pwm_q      <= 1'b0;
            dt_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pwm_q      <= pwm_d;
            dt_cnt_q   <= dt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign out_hi   = state_q[HI_BIT];
    assign out_lo   = state_q[LO_BIT];
    assign drop_cnt = drop_cnt_q;

    always_comb begin
        case (state_q)
            S_OFF:      state_o = 3'd0;
            S_LO_ON:    state_o = 3'd1;
            S_DT_TO_HI: state_o = 3'd2;
            S_HI_ON:    state_o = 3'd3;
            S_DT_TO_LO: state_o = 3'd4;
            default:    state_o = 3'd0;
        endcase
    end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: a run-length model of the gate pair checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pwm_deadtime;

    localparam int DT_W  = 4;
    localparam int CNT_W = 8;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             pwm_in = 1'b0;
    logic [DT_W-1:0]  dead_time = 4'd2;
    logic             clr_cnt = 1'b0;
    logic             out_hi;
    logic             out_lo;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] drop_cnt;

    pwm_deadtime #(.DT_W(DT_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pwm_in    (pwm_in),
        .dead_time (dead_time),
        .clr_cnt   (clr_cnt),
        .out_hi    (out_hi),
        .out_lo    (out_lo),
        .state_o   (state_o),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the output side follows the level of the registered PWM once that level
    // has persisted for more than D edges; a run that ends earlier is a dropped pulse.
    int   m_pq = 0, m_side = 0, m_run_v = 0, m_run_c = 0, m_run_d = 1, m_drop = 0;
    logic e_hi = 1'b0, e_lo = 1'b0;
    int   e_state = 0;

    always @(posedge clk) begin : model
        int a;
        int tgt;
        bit inc;
        inc = 1'b0;
        if (rst) begin
            m_pq = 0; m_side = 0; m_run_c = 0; m_drop = 0;
            e_hi = 1'b0; e_lo = 1'b0; e_state = 0;
        end else begin
            a    = m_pq;
            m_pq = int'(pwm_in);
            if (!en) begin
                m_side = 0; m_run_c = 0;
                e_hi = 1'b0; e_lo = 1'b0; e_state = 0;
            end else begin
                if (m_run_c == 0 || a != m_run_v) begin
                    if (m_run_c != 0 && m_side != ((m_run_v != 0) ? 2 : 1)) inc = 1'b1;
                    m_run_v = a;
                    m_run_c = 1;
                    m_run_d = (dead_time == 0) ? 1 : int'(dead_time);
                end else begin
                    m_run_c++;
                end
                tgt = (a != 0) ? 2 : 1;
                if (m_side != tgt && ((m_side == 0 && a == 0) || m_run_c > m_run_d)) m_side = tgt;
                if (m_side == tgt) begin
                    e_hi = (tgt == 2); e_lo = (tgt == 1); e_state = (tgt == 2) ? 3 : 1;
                end else begin
                    e_hi = 1'b0; e_lo = 1'b0; e_state = (a != 0) ? 2 : 4;
                end
            end
            if (clr_cnt) m_drop = 0;
            else if (inc && m_drop < SAT) m_drop++;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_out_hi", out_hi, e_hi);
            check("model_out_lo", out_lo, e_lo);
            check("model_state", state_o, e_state);
            check("model_drop_cnt", drop_cnt, m_drop);
            check("no_overlap", out_hi & out_lo, 0);
        end
    end

    // One clock edge with the given inputs; returns at the following falling edge.
    task automatic step(input logic p, input logic c = 1'b0);
        pwm_in  = p;
        clr_cnt = c;
        @(negedge clk);
        clr_cnt = 1'b0;
    endtask

    // Drive n periods of 10 cycles with w high cycles; count gate-on cycles in the last.
    task automatic run_periods(input int w, input int n, output int hi_c, output int lo_c);
        for (int p = 0; p < n; p++) begin
            hi_c = 0;
            lo_c = 0;
            for (int i = 0; i < 10; i++) begin
                step(i < w);
                hi_c += int'(out_hi);
                lo_c += int'(out_lo);
            end
        end
    endtask

    int h, l;

    initial begin
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        check("reset_state", state_o, 0);
        check("reset_out_hi", out_hi, 0);
        check("reset_out_lo", out_lo, 0);
        check("reset_drop", drop_cnt, 0);

        rst = 1'b0;
        step(1'b0);
        check("idle_off_state", state_o, 0);
        en = 1'b1;
        step(1'b0);
        check("first_lo_state", state_o, 1);
        check("first_lo_out_lo", out_lo, 1);
        check("first_lo_out_hi", out_hi, 0);

        dead_time = 4'd2;
        run_periods(5, 3, h, l);
        check("d2_w5_hi_cycles", h, 3);
        check("d2_w5_lo_cycles", l, 3);
        check("d2_w5_drop", drop_cnt, 0);

        run_periods(2, 4, h, l);
        check("d2_w2_hi_cycles", h, 0);
        check("d2_w2_lo_cycles", l, 8);
        check("d2_w2_drop", drop_cnt, 4);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        check("drop_before_clr", drop_cnt, 4);
        step(1'b0, 1'b1);
        check("clr_beats_inc", drop_cnt, 0);
        repeat (3) step(1'b0);

        dead_time = 4'd0;
        run_periods(5, 3, h, l);
        check("d0_hi_cycles", h, 4);
        check("d0_lo_cycles", l, 4);

        dead_time = 4'd2;
        repeat (6) step(1'b1);
        check("full_duty_state", state_o, 3);
        check("full_duty_hi", out_hi, 1);
        step(1'b0);
        step(1'b1);
        check("low_pulse_dt_state", state_o, 4);
        step(1'b1);
        check("low_pulse_abort_state", state_o, 3);
        check("low_pulse_drop", drop_cnt, 1);

        en = 1'b0;
        step(1'b1);
        check("en_off_hi", out_hi, 0);
        check("en_off_state", state_o, 0);
        dead_time = 4'd3;
        en = 1'b1;
        step(1'b1);
        check("en_on_dt_state", state_o, 2);
        step(1'b1);
        step(1'b1);
        check("en_on_dt_end_state", state_o, 2);
        check("en_on_dt_end_hi", out_hi, 0);
        step(1'b1);
        check("en_on_hi", out_hi, 1);
        check("en_on_hi_state", state_o, 3);

        dead_time = 4'd7;
        step(1'b0);
        step(1'b0);
        step(1'b0);
        check("mid_dt_lo_state", state_o, 4);
        rst = 1'b1;
        step(1'b0);
        check("rst_mid_dt_state", state_o, 0);
        check("rst_mid_dt_hi", out_hi, 0);
        check("rst_mid_dt_lo", out_lo, 0);
        check("rst_mid_dt_drop", drop_cnt, 0);
        rst = 1'b0;

        dead_time = 4'd2;
        for (int i = 0; i < 300; i++) begin
            step(1'b1);
            step(1'b0);
        end
        step(1'b0);
        step(1'b0);
        check("drop_saturated", drop_cnt, SAT);
        step(1'b0, 1'b1);
        check("drop_cleared", drop_cnt, 0);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
